// File: rtl/id_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | id_pkg : opcodes, ALU_OP encodings and control bundle for id_stage   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package id_pkg;

  localparam int REG_IDX_W = 5;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic [1:0] alu_op;
    logic       illegal;
  } ctrl_t;

  function automatic ctrl_t decode_ctrl(input logic [5:0] opcode);
    ctrl_t c;
    c = '0;
    case (opcode)
      OP_RTYPE: begin
        c.reg_dst   = 1'b1;
        c.reg_write = 1'b1;
        c.alu_op    = ALU_OP_FUNCT;
      end
      OP_LW: begin
        c.alu_src    = 1'b1;
        c.mem_to_reg = 1'b1;
        c.reg_write  = 1'b1;
        c.mem_read   = 1'b1;
        c.alu_op     = ALU_OP_ADD;
      end
      OP_SW: begin
        c.alu_src   = 1'b1;
        c.mem_write = 1'b1;
        c.alu_op    = ALU_OP_ADD;
      end
      OP_BEQ: begin
        c.branch = 1'b1;
        c.alu_op = ALU_OP_SUB;
      end
      OP_ADDI: begin
        c.alu_src   = 1'b1;
        c.reg_write = 1'b1;
        c.alu_op    = ALU_OP_ADD;
      end
      default: c.illegal = 1'b1;
    endcase
    return c;
  endfunction

  // Formats whose RT field is a source operand (and can therefore hit a load-use hazard)
  function automatic logic reads_rt(input logic [5:0] opcode);
    return (opcode == OP_RTYPE) || (opcode == OP_SW) || (opcode == OP_BEQ);
  endfunction

endpackage
`default_nettype wire

// File: rtl/id_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | id_if : IF/ID, write-back and ID/EX signals of the decode stage      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface id_if #(
  parameter int DATA_W = 32
);
  import id_pkg::*;

  logic [31:0]           next_ins_adr_i;
  logic [31:0]           cur_ins_i;
  logic                  wb_reg_write_i;
  logic [REG_IDX_W-1:0]  wb_write_reg_i;
  logic [DATA_W-1:0]     wb_write_data_i;
  logic                  flush_i;

  logic                  stall_o;
  logic [31:0]           next_ins_adr_o;
  logic [DATA_W-1:0]     rs_data_o;
  logic [DATA_W-1:0]     rt_data_o;
  logic [31:0]           imm_o;
  logic [REG_IDX_W-1:0]  rs_o;
  logic [REG_IDX_W-1:0]  rt_o;
  logic [REG_IDX_W-1:0]  rd_o;
  ctrl_t                 ctrl_o;

  modport master (
    output next_ins_adr_i, cur_ins_i, wb_reg_write_i, wb_write_reg_i,
           wb_write_data_i, flush_i,
    input  stall_o, next_ins_adr_o, rs_data_o, rt_data_o, imm_o,
           rs_o, rt_o, rd_o, ctrl_o
  );

  modport slave (
    input  next_ins_adr_i, cur_ins_i, wb_reg_write_i, wb_write_reg_i,
           wb_write_data_i, flush_i,
    output stall_o, next_ins_adr_o, rs_data_o, rt_data_o, imm_o,
           rs_o, rt_o, rd_o, ctrl_o
  );
endinterface
`default_nettype wire

// File: rtl/id_reg_file.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | id_reg_file : 2 async read / 1 sync write register file, r0 == 0     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module id_reg_file
  import id_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int REG_CNT = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 we_i,
  input  logic [REG_IDX_W-1:0] waddr_i,
  input  logic [DATA_W-1:0]    wdata_i,
  input  logic [REG_IDX_W-1:0] raddr_a_i,
  input  logic [REG_IDX_W-1:0] raddr_b_i,
  output logic [DATA_W-1:0]    rdata_a_o,
  output logic [DATA_W-1:0]    rdata_b_o
);

  logic [DATA_W-1:0] regs_q [REG_CNT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_CNT; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i && (waddr_i != '0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = (raddr_a_i == '0) ? '0 : regs_q[raddr_a_i];
  assign rdata_b_o = (raddr_b_i == '0) ? '0 : regs_q[raddr_b_i];

endmodule
`default_nettype wire

// File: rtl/id_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | id_stage : decode, load-use hazard detect, bypassed RF read, ID/EX   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module id_stage
  import id_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int REG_CNT = 32
) (
  input  logic clk,
  input  logic rst_n,
  id_if.slave  bus
);

  logic [5:0]           w_opcode;
  logic [REG_IDX_W-1:0] w_rs_idx;
  logic [REG_IDX_W-1:0] w_rt_idx;
  logic [REG_IDX_W-1:0] w_rd_idx;
  logic [DATA_W-1:0]    w_rf_a;
  logic [DATA_W-1:0]    w_rf_b;
  logic                 w_wb_valid;
  logic                 w_stall;
  logic                 w_bubble;

  logic [31:0]          adr_d,  adr_q;
  logic [DATA_W-1:0]    rsd_d,  rsd_q;
  logic [DATA_W-1:0]    rtd_d,  rtd_q;
  logic [31:0]          imm_d,  imm_q;
  logic [REG_IDX_W-1:0] rs_d,   rs_q;
  logic [REG_IDX_W-1:0] rt_d,   rt_q;
  logic [REG_IDX_W-1:0] rd_d,   rd_q;
  ctrl_t                ctrl_d, ctrl_q;

  assign w_opcode   = bus.cur_ins_i[31:26];
  assign w_rs_idx   = bus.cur_ins_i[25:21];
  assign w_rt_idx   = bus.cur_ins_i[20:16];
  assign w_rd_idx   = bus.cur_ins_i[15:11];
  assign w_wb_valid = bus.wb_reg_write_i && (bus.wb_write_reg_i != '0);

  id_reg_file #(
    .DATA_W  (DATA_W),
    .REG_CNT (REG_CNT)
  ) u_reg_file (
    .clk       (clk),
    .rst_n     (rst_n),
    .we_i      (bus.wb_reg_write_i),
    .waddr_i   (bus.wb_write_reg_i),
    .wdata_i   (bus.wb_write_data_i),
    .raddr_a_i (w_rs_idx),
    .raddr_b_i (w_rt_idx),
    .rdata_a_o (w_rf_a),
    .rdata_b_o (w_rf_b)
  );

  // Load in EX whose destination is a source of the instruction now in ID
  assign w_stall = ctrl_q.mem_read && (rt_q != '0) &&
                   ((rt_q == w_rs_idx) || (reads_rt(w_opcode) && (rt_q == w_rt_idx)));
  assign w_bubble = w_stall || bus.flush_i;

  always_comb begin
    adr_d  = '0;
    rsd_d  = '0;
    rtd_d  = '0;
    imm_d  = '0;
    rs_d   = '0;
    rt_d   = '0;
    rd_d   = '0;
    ctrl_d = '0;
    if (!w_bubble) begin
      adr_d  = bus.next_ins_adr_i;
      rsd_d  = (w_wb_valid && (bus.wb_write_reg_i == w_rs_idx)) ? bus.wb_write_data_i : w_rf_a;
      rtd_d  = (w_wb_valid && (bus.wb_write_reg_i == w_rt_idx)) ? bus.wb_write_data_i : w_rf_b;
      imm_d  = {{16{bus.cur_ins_i[15]}}, bus.cur_ins_i[15:0]};
      rs_d   = w_rs_idx;
      rt_d   = w_rt_idx;
      rd_d   = w_rd_idx;
      ctrl_d = decode_ctrl(w_opcode);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      adr_q  <= '0;
      rsd_q  <= '0;
      rtd_q  <= '0;
      imm_q  <= '0;
      rs_q   <= '0;
      rt_q   <= '0;
      rd_q   <= '0;
      ctrl_q <= '0;
    end else begin
      adr_q  <= adr_d;
      rsd_q  <= rsd_d;
      rtd_q  <= rtd_d;
      imm_q  <= imm_d;
      rs_q   <= rs_d;
      rt_q   <= rt_d;
      rd_q   <= rd_d;
      ctrl_q <= ctrl_d;
    end
  end

  assign bus.stall_o        = w_stall;
  assign bus.next_ins_adr_o = adr_q;
  assign bus.rs_data_o      = rsd_q;
  assign bus.rt_data_o      = rtd_q;
  assign bus.imm_o          = imm_q;
  assign bus.rs_o           = rs_q;
  assign bus.rt_o           = rt_q;
  assign bus.rd_o           = rd_q;
  assign bus.ctrl_o         = ctrl_q;

endmodule
`default_nettype wire

// File: tb/tb_id_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_id_stage : directed + randomized bench against a decode model     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_id_stage;
  import id_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  id_if #(.DATA_W(32)) bus ();

  id_stage #(
    .DATA_W  (32),
    .REG_CNT (32)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Architectural model: register contents plus the expected ID/EX latch
  logic [31:0] m_regs [32];
  logic [9:0]  m_ctrl;
  logic [31:0] m_adr, m_rsd, m_rtd, m_imm;
  logic [4:0]  m_rs, m_rt, m_rd;
  logic        obs_stall;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  // Control bits in order reg_dst,alu_src,mem_to_reg,reg_write,mem_read,mem_write,branch,alu_op[1:0],illegal
  function automatic logic [9:0] ref_ctrl(input logic [5:0] op);
    case (op)
      6'h00:   return 10'b1001000100;
      6'h23:   return 10'b0111100000;
      6'h2B:   return 10'b0100010000;
      6'h04:   return 10'b0000001010;
      6'h08:   return 10'b0101000000;
      default: return 10'b0000000001;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
    m_ctrl = '0; m_adr = '0; m_rsd = '0; m_rtd = '0; m_imm = '0;
    m_rs = '0; m_rt = '0; m_rd = '0;
  endtask

  task automatic check_outputs();
    check("adr",  bus.next_ins_adr_o, m_adr);
    check("rsd",  bus.rs_data_o, m_rsd);
    check("rtd",  bus.rt_data_o, m_rtd);
    check("imm",  bus.imm_o, m_imm);
    check("rs",   {27'b0, bus.rs_o}, {27'b0, m_rs});
    check("rt",   {27'b0, bus.rt_o}, {27'b0, m_rt});
    check("rd",   {27'b0, bus.rd_o}, {27'b0, m_rd});
    check("ctrl", {22'b0, bus.ctrl_o}, {22'b0, m_ctrl});
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_adr"},   bus.next_ins_adr_o, 32'h0);
    check({tag, "_rsd"},   bus.rs_data_o, 32'h0);
    check({tag, "_rtd"},   bus.rt_data_o, 32'h0);
    check({tag, "_imm"},   bus.imm_o, 32'h0);
    check({tag, "_regs"},  {17'b0, bus.rs_o, bus.rt_o, bus.rd_o}, 32'h0);
    check({tag, "_ctrl"},  {22'b0, bus.ctrl_o}, 32'h0);
    check({tag, "_stall"}, {31'b0, bus.stall_o}, 32'h0);
  endtask

  // Starts and ends on a falling edge; one instruction presented for one rising edge
  task automatic step(input logic [31:0] ins, input logic we, input logic [4:0] wreg,
                      input logic [31:0] wdata, input logic flush);
    logic [31:0] adr;
    logic [5:0]  op;
    logic [4:0]  rs, rt;
    logic        exp_stall;
    adr = $urandom;
    op  = ins[31:26];
    rs  = ins[25:21];
    rt  = ins[20:16];
    bus.next_ins_adr_i  = adr;
    bus.cur_ins_i       = ins;
    bus.wb_reg_write_i  = we;
    bus.wb_write_reg_i  = wreg;
    bus.wb_write_data_i = wdata;
    bus.flush_i         = flush;
    #1;
    exp_stall = m_ctrl[5] && (m_rt != 5'd0) &&
                ((m_rt == rs) || ((op == 6'h00 || op == 6'h2B || op == 6'h04) && (m_rt == rt)));
    obs_stall = bus.stall_o;
    check("stall", {31'b0, bus.stall_o}, {31'b0, exp_stall});
    if (exp_stall || flush) begin
      m_ctrl = '0; m_adr = '0; m_rsd = '0; m_rtd = '0; m_imm = '0;
      m_rs = '0; m_rt = '0; m_rd = '0;
    end else begin
      m_ctrl = ref_ctrl(op);
      m_adr  = adr;
      m_rs   = rs;
      m_rt   = rt;
      m_rd   = ins[15:11];
      m_imm  = {{16{ins[15]}}, ins[15:0]};
      m_rsd  = (we && wreg != 5'd0 && wreg == rs) ? wdata : m_regs[rs];
      m_rtd  = (we && wreg != 5'd0 && wreg == rt) ? wdata : m_regs[rt];
    end
    if (we && wreg != 5'd0) m_regs[wreg] = wdata;
    @(posedge clk);
    #1;
    check_outputs();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0]  ops [6];
    logic [31:0] ins;
    ops[0] = 6'h00; ops[1] = 6'h23; ops[2] = 6'h2B; ops[3] = 6'h04; ops[4] = 6'h08; ops[5] = 6'h3F;

    bus.next_ins_adr_i  = '0;
    bus.cur_ins_i       = '0;
    bus.wb_reg_write_i  = 1'b0;
    bus.wb_write_reg_i  = '0;
    bus.wb_write_data_i = '0;
    bus.flush_i         = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_zero("rst");
    rst_n = 1'b1;

    // Write r5 then read it twice with add r6,r5,r5
    step(32'h0000_0000, 1'b1, 5'd5, 32'h0000_1234, 1'b0);
    step(32'h00A5_3020, 1'b0, 5'd0, 32'h0, 1'b0);
    check("add_rsd", bus.rs_data_o, 32'h0000_1234);
    check("add_rtd", bus.rt_data_o, 32'h0000_1234);
    check("add_regdst", {31'b0, bus.ctrl_o.reg_dst}, 32'h1);
    check("add_aluop", {30'b0, bus.ctrl_o.alu_op}, 32'h2);

    // Same-cycle write-through bypass with lw r8,-4(r7)
    step(32'h8CE8_FFFC, 1'b1, 5'd7, 32'hDEAD_BEEF, 1'b0);
    check("byp_rsd", bus.rs_data_o, 32'hDEAD_BEEF);
    check("byp_imm", bus.imm_o, 32'hFFFF_FFFC);
    check("byp_memrd", {31'b0, bus.ctrl_o.mem_read}, 32'h1);

    // Load-use: lw r8,0(r7); add r9,r8,r1 held one cycle
    step(32'h8CE8_0000, 1'b0, 5'd0, 32'h0, 1'b0);
    step(32'h0101_4820, 1'b0, 5'd0, 32'h0, 1'b0);
    check("lu_stall", {31'b0, obs_stall}, 32'h1);
    check("lu_bubble", {22'b0, bus.ctrl_o}, 32'h0);
    step(32'h0101_4820, 1'b0, 5'd0, 32'h0, 1'b0);
    check("lu_release", {31'b0, obs_stall}, 32'h0);
    check("lu_add", {22'b0, bus.ctrl_o}, {22'b0, 10'b1001000100});

    // r0 stays zero and never causes a hazard
    step(32'h0000_0000, 1'b1, 5'd0, 32'h0000_0055, 1'b0);
    step(32'h0000_3020, 1'b0, 5'd0, 32'h0, 1'b0);
    check("r0_read", bus.rs_data_o, 32'h0);
    step(32'h8CE0_0000, 1'b0, 5'd0, 32'h0, 1'b0);
    step(32'h0000_4820, 1'b0, 5'd0, 32'h0, 1'b0);
    check("r0_nostall", {31'b0, obs_stall}, 32'h0);

    // Flushed beq, then an illegal opcode
    step(32'h10A6_0003, 1'b0, 5'd0, 32'h0, 1'b1);
    check("flush_ctrl", {22'b0, bus.ctrl_o}, 32'h0);
    step(32'hFC00_0000, 1'b0, 5'd0, 32'h0, 1'b0);
    check("illegal", {22'b0, bus.ctrl_o}, 32'h1);

    // Reset while a load-use stall is pending
    step(32'h8CE8_0000, 1'b0, 5'd0, 32'h0, 1'b0);
    bus.cur_ins_i      = 32'h0101_4820;
    bus.wb_reg_write_i = 1'b0;
    bus.flush_i        = 1'b0;
    #1;
    check("mid_stall", {31'b0, bus.stall_o}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("arst");
    bus.wb_reg_write_i  = 1'b1;
    bus.wb_write_reg_i  = 5'd5;
    bus.wb_write_data_i = 32'hAAAA_5555;
    @(posedge clk);
    #1;
    check_zero("arst_hold");
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    step(32'h00A7_3020, 1'b0, 5'd0, 32'h0, 1'b0);
    check("post_rst_r5", bus.rs_data_o, 32'h0);
    check("post_rst_r7", bus.rt_data_o, 32'h0);

    // Random traffic on a narrow register window to provoke hazards and bypasses
    for (int n = 0; n < 400; n++) begin
      ins = {ops[$urandom_range(0, 5)], 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
             16'($urandom)};
      step(ins, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
           ($urandom_range(0, 9) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
